// File: rtl/axis_bcd_scheduler_pkg.sv
// Shared constants, FSM encoding and digit helper for the axis BCD scheduler.
package axis_bcd_scheduler_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DIGITS_DEF = 5;

  localparam logic [1:0] AX_X = 2'd0;
  localparam logic [1:0] AX_Y = 2'd1;
  localparam logic [1:0] AX_Z = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_LOAD,
    ST_SHIFT,
    ST_STORE,
    ST_WAIT_FRAME,
    ST_COMMIT
  } state_e;

  // Double-dabble correction applied to each digit before every shift.
  function automatic logic [3:0] dd_adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/axis_bcd_scheduler_bcd_shift_engine.sv
// Sequential double-dabble converter: load a magnitude, then one add-3/shift per step.
module bcd_shift_engine
  import axis_bcd_scheduler_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [DATA_W-1:0]     mag_i,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [4*DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
  logic [DATA_W-1:0]   mag_q, mag_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = dd_adj(bcd_q[4*gi +: 4]);
    end
  endgenerate

  always_comb begin
    bcd_d = bcd_q;
    mag_d = mag_q;
    cnt_d = cnt_q;
    if (load_i) begin
      bcd_d = '0;
      mag_d = mag_i;
      cnt_d = CNT_W'(DATA_W);
    end else if (step_i && cnt_q != '0) begin
      {bcd_d, mag_d} = {bcd_adj[4*DIGITS-2:0], mag_q, 1'b0};
      cnt_d          = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q <= '0;
      mag_q <= '0;
      cnt_q <= '0;
    end else begin
      bcd_q <= bcd_d;
      mag_q <= mag_d;
      cnt_q <= cnt_d;
    end
  end

  // Asserted during the final step so the FSM leaves SHIFT after exactly DATA_W cycles.
  assign done_o = (cnt_q == CNT_W'(1));
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/axis_bcd_scheduler.sv
// Time-multiplexes one BCD engine over X/Y/Z and publishes all three results
// together, optionally aligned to a frame boundary.
module axis_bcd_scheduler
  import axis_bcd_scheduler_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int DIGITS        = DIGITS_DEF,
  parameter int SYNC_TO_FRAME = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic signed [DATA_W-1:0] data_x,
  input  logic signed [DATA_W-1:0] data_y,
  input  logic signed [DATA_W-1:0] data_z,
  input  logic                     frame_start,
  output logic                     x_neg,
  output logic                     y_neg,
  output logic                     z_neg,
  output logic [4*DIGITS-1:0]      x_bcd,
  output logic [4*DIGITS-1:0]      y_bcd,
  output logic [4*DIGITS-1:0]      z_bcd,
  output logic                     commit,
  output logic                     busy,
  output logic [7:0]               dropped
);

  state_e                        state_q, state_d;
  logic                          pending_q, pending_d;
  logic [7:0]                    dropped_q, dropped_d;
  logic [1:0]                    axis_q, axis_d;
  logic                          neg_q, neg_d;
  logic [2:0][DATA_W-1:0]        snap_q, snap_d;
  logic [2:0]                    sh_neg_q, sh_neg_d, out_neg_q, out_neg_d;
  logic [2:0][4*DIGITS-1:0]      sh_bcd_q, sh_bcd_d, out_bcd_q, out_bcd_d;

  logic                          eng_load, eng_step, eng_done;
  logic [4*DIGITS-1:0]           eng_bcd;
  logic [DATA_W-1:0]             cur_sample;
  logic [DATA_W:0]               ext_sample, mag_full;

  // One extra bit so the most negative sample negates without overflow.
  assign cur_sample = snap_q[axis_q];
  assign ext_sample = {cur_sample[DATA_W-1], cur_sample};
  assign mag_full   = cur_sample[DATA_W-1] ? (~ext_sample + 1'b1) : ext_sample;

  bcd_shift_engine #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_engine (
    .clk    (clk),
    .rst    (rst),
    .load_i (eng_load),
    .step_i (eng_step),
    .mag_i  (mag_full[DATA_W-1:0]),
    .done_o (eng_done),
    .bcd_o  (eng_bcd)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    dropped_d = dropped_q;
    axis_d    = axis_q;
    neg_d     = neg_q;
    snap_d    = snap_q;
    sh_neg_d  = sh_neg_q;
    sh_bcd_d  = sh_bcd_q;
    out_neg_d = out_neg_q;
    out_bcd_d = out_bcd_q;
    eng_load  = 1'b0;
    eng_step  = 1'b0;

    if (tick && state_q != ST_IDLE) begin
      if (!pending_q)               pending_d = 1'b1;
      else if (dropped_q != 8'hFF)  dropped_d = dropped_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick || pending_q) begin
          state_d   = ST_CAPTURE;
          pending_d = 1'b0;
        end
      end
      ST_CAPTURE: begin
        snap_d  = {data_z, data_y, data_x};
        axis_d  = AX_X;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        eng_load = 1'b1;
        neg_d    = cur_sample[DATA_W-1];
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        eng_step = 1'b1;
        if (eng_done) state_d = ST_STORE;
      end
      ST_STORE: begin
        sh_neg_d[axis_q] = neg_q;
        sh_bcd_d[axis_q] = eng_bcd;
        if (axis_q < AX_Z) begin
          axis_d  = axis_q + 2'd1;
          state_d = ST_LOAD;
        end else begin
          state_d = (SYNC_TO_FRAME != 0) ? ST_WAIT_FRAME : ST_COMMIT;
        end
      end
      ST_WAIT_FRAME: begin
        if (frame_start) state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Load outputs on entry to COMMIT (Z shadow bypassed) so they appear with the pulse.
    if (state_d == ST_COMMIT && state_q != ST_COMMIT) begin
      out_neg_d = sh_neg_d;
      out_bcd_d = sh_bcd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      dropped_q <= '0;
      axis_q    <= AX_X;
      neg_q     <= 1'b0;
      snap_q    <= '0;
      sh_neg_q  <= '0;
      sh_bcd_q  <= '0;
      out_neg_q <= '0;
      out_bcd_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
      axis_q    <= axis_d;
      neg_q     <= neg_d;
      snap_q    <= snap_d;
      sh_neg_q  <= sh_neg_d;
      sh_bcd_q  <= sh_bcd_d;
      out_neg_q <= out_neg_d;
      out_bcd_q <= out_bcd_d;
    end
  end

  assign x_neg   = out_neg_q[AX_X];
  assign y_neg   = out_neg_q[AX_Y];
  assign z_neg   = out_neg_q[AX_Z];
  assign x_bcd   = out_bcd_q[AX_X];
  assign y_bcd   = out_bcd_q[AX_Y];
  assign z_bcd   = out_bcd_q[AX_Z];
  assign commit  = (state_q == ST_COMMIT);
  assign busy    = (state_q != ST_IDLE);
  assign dropped = dropped_q;

endmodule

// File: tb/tb_axis_bcd_scheduler.sv
// Directed bench: dut_a commits on frame_start, dut_b commits right after conversion.
module tb_axis_bcd_scheduler;

  localparam int DATA_W = 16;
  localparam int DIGITS = 5;
  localparam int BW     = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_a = 1'b0, tick_b = 1'b0, frame_start = 1'b0;
  logic signed [DATA_W-1:0] data_x = '0, data_y = '0, data_z = '0;

  logic a_xn, a_yn, a_zn, a_commit, a_busy;
  logic [BW-1:0] a_xb, a_yb, a_zb;
  logic [7:0] a_drop;
  logic b_xn, b_yn, b_zn, b_commit, b_busy;
  logic [BW-1:0] b_xb, b_yb, b_zb;
  logic [7:0] b_drop;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axis_bcd_scheduler #(.DATA_W(DATA_W), .DIGITS(DIGITS), .SYNC_TO_FRAME(1)) dut_a (
    .clk(clk), .rst(rst), .tick(tick_a),
    .data_x(data_x), .data_y(data_y), .data_z(data_z), .frame_start(frame_start),
    .x_neg(a_xn), .y_neg(a_yn), .z_neg(a_zn),
    .x_bcd(a_xb), .y_bcd(a_yb), .z_bcd(a_zb),
    .commit(a_commit), .busy(a_busy), .dropped(a_drop)
  );

  axis_bcd_scheduler #(.DATA_W(DATA_W), .DIGITS(DIGITS), .SYNC_TO_FRAME(0)) dut_b (
    .clk(clk), .rst(rst), .tick(tick_b),
    .data_x(data_x), .data_y(data_y), .data_z(data_z), .frame_start(frame_start),
    .x_neg(b_xn), .y_neg(b_yn), .z_neg(b_zn),
    .x_bcd(b_xb), .y_bcd(b_yb), .z_bcd(b_zb),
    .commit(b_commit), .busy(b_busy), .dropped(b_drop)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick_a();
    tick_a = 1'b1;
    cyc(1);
    tick_a = 1'b0;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    n_tests++;
    if (a_busy !== 1'b0 || a_commit !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: busy=%b commit=%b expected 0 0", a_busy, a_commit);
    end
    n_tests++;
    if ({a_xn, a_yn, a_zn, a_xb, a_yb, a_zb} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: x=%h y=%h z=%h expected all 0", a_xb, a_yb, a_zb);
    end
    n_tests++;
    if (a_drop !== 8'd0) begin
      n_fail++; $display("FAIL reset_dropped: got %0d expected 0", a_drop);
    end
    rst = 1'b0;
    cyc(1);
    n_tests++;
    if (b_busy !== 1'b0 || b_commit !== 1'b0 || b_xb !== '0) begin
      n_fail++; $display("FAIL reset_b: busy=%b commit=%b x=%h expected 0 0 0", b_busy, b_commit, b_xb);
    end
  endtask

  task automatic test_frame_sync();
    bit bad = 1'b0;
    data_x = 16'sd123; data_y = -16'sd45; data_z = 16'sd0;
    pulse_tick_a();
    n_tests++;
    if (a_busy !== 1'b1) begin
      n_fail++; $display("FAIL sync_busy_start: got %b expected 1", a_busy);
    end
    for (int k = 0; k < 199; k++) begin
      if (a_commit !== 1'b0 || a_xb !== '0 || a_yb !== '0 || a_yn !== 1'b0) bad = 1'b1;
      cyc(1);
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL sync_hold: outputs changed before frame_start, expected held at 0");
    end
    n_tests++;
    if (a_busy !== 1'b1) begin
      n_fail++; $display("FAIL sync_waiting: busy=%b expected 1", a_busy);
    end
    frame_pulse();
    n_tests++;
    if (a_commit !== 1'b1) begin
      n_fail++; $display("FAIL sync_commit_pulse: got %b expected 1", a_commit);
    end
    n_tests++;
    if (a_xb !== 20'h00123 || a_xn !== 1'b0 || a_yb !== 20'h00045 || a_yn !== 1'b1 ||
        a_zb !== 20'h00000 || a_zn !== 1'b0) begin
      n_fail++; $display("FAIL sync_values: x=%b/%h y=%b/%h z=%b/%h expected 0/00123 1/00045 0/00000",
                         a_xn, a_xb, a_yn, a_yb, a_zn, a_zb);
    end
    cyc(1);
    n_tests++;
    if (a_commit !== 1'b0 || a_busy !== 1'b0 || a_xb !== 20'h00123) begin
      n_fail++; $display("FAIL sync_after: commit=%b busy=%b x=%h expected 0 0 00123", a_commit, a_busy, a_xb);
    end
  endtask

  task automatic test_extremes();
    data_x = -16'sd32768; data_y = 16'sd32767; data_z = -16'sd1;
    pulse_tick_a();
    cyc(60);
    frame_pulse();
    n_tests++;
    if (a_xb !== 20'h32768 || a_xn !== 1'b1) begin
      n_fail++; $display("FAIL extreme_x: got %b/%h expected 1/32768", a_xn, a_xb);
    end
    n_tests++;
    if (a_yb !== 20'h32767 || a_yn !== 1'b0) begin
      n_fail++; $display("FAIL extreme_y: got %b/%h expected 0/32767", a_yn, a_yb);
    end
    n_tests++;
    if (a_zb !== 20'h00001 || a_zn !== 1'b1) begin
      n_fail++; $display("FAIL extreme_z: got %b/%h expected 1/00001", a_zn, a_zb);
    end
    cyc(1);
  endtask

  task automatic test_immediate();
    int first_commit = -1;
    bit busy_ok = 1'b1;
    data_x = 16'sd7; data_y = -16'sd300; data_z = 16'sd9999;
    tick_b = 1'b1;
    for (int k = 1; k <= 57; k++) begin
      cyc(1);
      if (k == 1) tick_b = 1'b0;
      if (b_commit === 1'b1 && first_commit < 0) first_commit = k;
      if (k <= 56 && b_busy !== 1'b1) busy_ok = 1'b0;
    end
    n_tests++;
    if (first_commit != 56) begin
      n_fail++; $display("FAIL imm_commit_time: got T+%0d expected T+56", first_commit);
    end
    n_tests++;
    if (!busy_ok || b_busy !== 1'b0) begin
      n_fail++; $display("FAIL imm_busy_window: window_ok=%b busy@T+57=%b expected 1 0", busy_ok, b_busy);
    end
    n_tests++;
    if (b_xb !== 20'h00007 || b_xn !== 1'b0 || b_yb !== 20'h00300 || b_yn !== 1'b1 ||
        b_zb !== 20'h09999 || b_zn !== 1'b0) begin
      n_fail++; $display("FAIL imm_values: x=%b/%h y=%b/%h z=%b/%h expected 0/00007 1/00300 0/09999",
                         b_xn, b_xb, b_yn, b_yb, b_zn, b_zb);
    end
  endtask

  task automatic test_snapshot_drop();
    data_x = 16'sd555; data_y = 16'sd1; data_z = 16'sd2;
    tick_a = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      cyc(1);
      if (k == 1) tick_a = 1'b0;
      if (k == 10) data_x = 16'sd999;
      if (k == 20 || k == 30 || k == 40) tick_a = 1'b1;
      if (k == 21 || k == 31 || k == 41) tick_a = 1'b0;
    end
    n_tests++;
    if (a_drop !== 8'd2) begin
      n_fail++; $display("FAIL drop_count: got %0d expected 2", a_drop);
    end
    cyc(15);
    frame_pulse();
    n_tests++;
    if (a_commit !== 1'b1 || a_xb !== 20'h00555 || a_yb !== 20'h00001 || a_zb !== 20'h00002) begin
      n_fail++; $display("FAIL snapshot_values: commit=%b x=%h y=%h z=%h expected 1 00555 00001 00002",
                         a_commit, a_xb, a_yb, a_zb);
    end
    cyc(1);
    n_tests++;
    if (a_busy !== 1'b0) begin
      n_fail++; $display("FAIL pending_idle: busy=%b expected 0", a_busy);
    end
    cyc(1);
    n_tests++;
    if (a_busy !== 1'b1) begin
      n_fail++; $display("FAIL pending_restart: busy=%b expected 1", a_busy);
    end
    cyc(60);
    n_tests++;
    if (a_xb !== 20'h00555 || a_commit !== 1'b0) begin
      n_fail++; $display("FAIL reconv_hold: x=%h commit=%b expected 00555 0", a_xb, a_commit);
    end
    frame_pulse();
    n_tests++;
    if (a_commit !== 1'b1 || a_xb !== 20'h00999 || a_drop !== 8'd2) begin
      n_fail++; $display("FAIL reconv_values: commit=%b x=%h dropped=%0d expected 1 00999 2",
                         a_commit, a_xb, a_drop);
    end
    cyc(1);
  endtask

  task automatic test_frame_ignore();
    int first_commit = -1;
    data_x = -16'sd9; data_y = 16'sd10000; data_z = -16'sd12345;
    tick_a = 1'b1;
    for (int k = 1; k <= 302; k++) begin
      cyc(1);
      if (a_commit === 1'b1 && first_commit < 0) first_commit = k;
      if (k == 1) tick_a = 1'b0;
      if (k == 20 || k == 300) frame_start = 1'b1;
      if (k == 21 || k == 301) frame_start = 1'b0;
    end
    n_tests++;
    if (first_commit != 301) begin
      n_fail++; $display("FAIL frame_ignore_time: got T+%0d expected T+301", first_commit);
    end
    n_tests++;
    if (a_xb !== 20'h00009 || a_xn !== 1'b1 || a_yb !== 20'h10000 || a_yn !== 1'b0 ||
        a_zb !== 20'h12345 || a_zn !== 1'b1) begin
      n_fail++; $display("FAIL frame_ignore_values: x=%b/%h y=%b/%h z=%b/%h expected 1/00009 0/10000 1/12345",
                         a_xn, a_xb, a_yn, a_yb, a_zn, a_zb);
    end
  endtask

  task automatic test_reset_mid();
    data_x = 16'sd4321; data_y = 16'sd5; data_z = 16'sd6;
    pulse_tick_a();
    cyc(24);
    n_tests++;
    if (a_busy !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre: busy=%b expected 1", a_busy);
    end
    rst = 1'b1;
    cyc(1);
    n_tests++;
    if (a_busy !== 1'b0 || a_commit !== 1'b0 || a_drop !== 8'd0) begin
      n_fail++; $display("FAIL midreset_ctrl: busy=%b commit=%b dropped=%0d expected 0 0 0",
                         a_busy, a_commit, a_drop);
    end
    n_tests++;
    if ({a_xn, a_yn, a_zn, a_xb, a_yb, a_zb} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: x=%b/%h y=%b/%h z=%b/%h expected all 0",
                         a_xn, a_xb, a_yn, a_yb, a_zn, a_zb);
    end
    rst = 1'b0;
    data_x = 16'sd1; data_y = -16'sd2; data_z = 16'sd3;
    pulse_tick_a();
    cyc(60);
    frame_pulse();
    n_tests++;
    if (a_commit !== 1'b1 || a_xb !== 20'h00001 || a_xn !== 1'b0 || a_yb !== 20'h00002 ||
        a_yn !== 1'b1 || a_zb !== 20'h00003 || a_zn !== 1'b0) begin
      n_fail++; $display("FAIL midreset_reconv: commit=%b x=%b/%h y=%b/%h z=%b/%h expected 1 0/00001 1/00002 0/00003",
                         a_commit, a_xn, a_xb, a_yn, a_yb, a_zn, a_zb);
    end
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1);
    test_reset();
    test_frame_sync();
    test_extremes();
    test_immediate();
    test_snapshot_drop();
    test_frame_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
